// File: rtl/mem_load_store_unit_if.sv
// MEM-stage bus: pipeline request/response signals plus the data-memory port.
// master = pipeline and memory side, slave = the load/store unit.
interface mem_load_store_unit_if;
  logic [31:0] ALU_Result_MEM;
  logic [31:0] Write_Data_MEM;
  logic        MemRead_MEM;
  logic        MemWrite_MEM;
  logic [1:0]  Mem_Size_MEM;
  logic        Mem_Unsigned_MEM;
  logic [31:0] Read_Data_MEM;
  logic        Stall_MEM;
  logic        Addr_Error_MEM;
  logic [31:0] Mem_Addr;
  logic        Mem_Read;
  logic        Mem_Write;
  logic [31:0] Mem_Write_Data;
  logic [31:0] Mem_Read_Data;

  modport master (
    output ALU_Result_MEM, Write_Data_MEM, MemRead_MEM, MemWrite_MEM,
           Mem_Size_MEM, Mem_Unsigned_MEM, Mem_Read_Data,
    input  Read_Data_MEM, Stall_MEM, Addr_Error_MEM, Mem_Addr,
           Mem_Read, Mem_Write, Mem_Write_Data
  );

  modport slave (
    input  ALU_Result_MEM, Write_Data_MEM, MemRead_MEM, MemWrite_MEM,
           Mem_Size_MEM, Mem_Unsigned_MEM, Mem_Read_Data,
    output Read_Data_MEM, Stall_MEM, Addr_Error_MEM, Mem_Addr,
           Mem_Read, Mem_Write, Mem_Write_Data
  );
endinterface

// File: rtl/mem_load_store_unit.sv
// MEM-stage load/store unit: lane extraction and extension for loads,
// single-cycle word stores and read-modify-write for byte/halfword stores.
module mem_load_store_unit #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input logic                   Clk,
  input logic                   Reset,
  mem_load_store_unit_if.slave  bus
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_HOLD = 2'd1,
    RMW_WRITE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [XLEN-1:0]   r_read_data;
  logic [XLEN-1:0]   r_merge_buf;

  logic [1:0]        w_off;
  logic [1:0]        w_size;
  logic [XLEN-1:0]   w_word_index;
  logic              w_req;
  logic              w_reject;
  logic [4:0]        w_byte_shift;
  logic [4:0]        w_half_shift;
  logic [7:0]        w_lane_byte;
  logic [15:0]       w_lane_half;
  logic [XLEN-1:0]   w_load_ext;
  logic [XLEN-1:0]   w_byte_mask;
  logic [XLEN-1:0]   w_half_mask;
  logic [XLEN-1:0]   w_merged;

  logic              w_mem_read;
  logic              w_mem_write;
  logic [XLEN-1:0]   w_mem_wdata;
  logic              w_stall;
  logic              w_addr_err;
  logic              w_merge_load;
  logic [XLEN-1:0]   w_rd_next;

  assign w_off        = bus.ALU_Result_MEM[1:0];
  assign w_size       = bus.Mem_Size_MEM;
  assign w_word_index = {2'b00, bus.ALU_Result_MEM[31:2]};
  assign w_req        = bus.MemRead_MEM | bus.MemWrite_MEM;

  // Access legality: conflicting request, illegal size, misalignment, range
  assign w_reject = (bus.MemRead_MEM & bus.MemWrite_MEM)
                  | (w_size == 2'b11)
                  | ((w_size == 2'b01) & w_off[0])
                  | ((w_size == 2'b10) & (w_off != 2'b00))
                  | (w_word_index >= XLEN'(DEPTH_WORDS));

  assign w_byte_shift = {w_off, 3'b000};
  assign w_half_shift = {w_off[1], 4'b0000};
  assign w_lane_byte  = 8'(bus.Mem_Read_Data >> w_byte_shift);
  assign w_lane_half  = 16'(bus.Mem_Read_Data >> w_half_shift);

  always_comb begin
    w_load_ext = bus.Mem_Read_Data;
    case (w_size)
      2'b00:   w_load_ext = bus.Mem_Unsigned_MEM ? {24'h0, w_lane_byte}
                                                 : {{24{w_lane_byte[7]}}, w_lane_byte};
      2'b01:   w_load_ext = bus.Mem_Unsigned_MEM ? {16'h0, w_lane_half}
                                                 : {{16{w_lane_half[15]}}, w_lane_half};
      default: w_load_ext = bus.Mem_Read_Data;
    endcase
  end

  // Replace the target lane of the captured word with the store data
  assign w_byte_mask = XLEN'(32'h0000_00FF) << w_byte_shift;
  assign w_half_mask = XLEN'(32'h0000_FFFF) << w_half_shift;

  always_comb begin
    w_merged = bus.Write_Data_MEM;
    if (w_size == 2'b00) begin
      w_merged = (r_merge_buf & ~w_byte_mask)
               | (XLEN'(bus.Write_Data_MEM[7:0]) << w_byte_shift);
    end else if (w_size == 2'b01) begin
      w_merged = (r_merge_buf & ~w_half_mask)
               | (XLEN'(bus.Write_Data_MEM[15:0]) << w_half_shift);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_wdata  = '0;
    w_stall      = 1'b0;
    w_addr_err   = 1'b0;
    w_merge_load = 1'b0;
    w_rd_next    = r_read_data;

    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_reject) begin
            w_addr_err = 1'b1;
            w_rd_next  = '0;
          end else if (bus.MemRead_MEM) begin
            w_mem_read   = 1'b1;
            w_stall      = 1'b1;
            w_rd_next    = w_load_ext;
            w_next_state = LOAD_HOLD;
          end else if (w_size == 2'b10) begin
            w_mem_write = 1'b1;
            w_mem_wdata = bus.Write_Data_MEM;
          end else begin
            w_mem_read   = 1'b1;
            w_stall      = 1'b1;
            w_merge_load = 1'b1;
            w_next_state = RMW_WRITE;
          end
        end
      end
      LOAD_HOLD: w_next_state = IDLE;
      RMW_WRITE: begin
        w_mem_write  = 1'b1;
        w_mem_wdata  = w_merged;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase

    // Reset suppresses every strobe, including a pending RMW write
    if (Reset) begin
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_stall     = 1'b0;
      w_addr_err  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_read_data <= '0;
      r_merge_buf <= '0;
    end else begin
      r_state     <= w_next_state;
      r_read_data <= w_rd_next;
      if (w_merge_load) begin
        r_merge_buf <= bus.Mem_Read_Data;
      end
    end
  end

  assign bus.Read_Data_MEM  = r_read_data;
  assign bus.Stall_MEM      = w_stall;
  assign bus.Addr_Error_MEM = w_addr_err;
  assign bus.Mem_Addr       = w_word_index;
  assign bus.Mem_Read       = w_mem_read;
  assign bus.Mem_Write      = w_mem_write;
  assign bus.Mem_Write_Data = w_mem_wdata;

endmodule

// File: tb/tb_mem_load_store_unit.sv
// Bench for mem_load_store_unit: directed vector table, reset corner cases and
// random accesses checked against a word-array reference model.
module tb_mem_load_store_unit;

  localparam int unsigned DEPTH = 1024;

  logic Clk = 1'b0;
  logic Reset;

  mem_load_store_unit_if bus();

  mem_load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Data memory attached to the unit, with a bench-side preload port
  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [31:0] pre_data;

  assign bus.Mem_Read_Data = mem[bus.Mem_Addr[9:0]];

  always @(posedge Clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (bus.Mem_Write && bus.Mem_Addr < 32'(DEPTH)) mem[bus.Mem_Addr[9:0]] <= bus.Mem_Write_Data;
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_rd;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input bit rd, input bit wr,
                       input logic [1:0] size, input bit uns);
    bus.ALU_Result_MEM   = addr;
    bus.Write_Data_MEM   = wdata;
    bus.MemRead_MEM      = rd;
    bus.MemWrite_MEM     = wr;
    bus.Mem_Size_MEM     = size;
    bus.Mem_Unsigned_MEM = uns;
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge Clk);
    pre_we = 1'b1; pre_idx = 10'(idx); pre_data = val;
    ref_mem[idx] = val;
  endtask

  // Reference model: whole-transaction effect from the access rules
  task automatic model(input logic [31:0] addr, input logic [31:0] wdata, input bit rd, input bit wr,
                       input logic [1:0] size, input bit uns,
                       output bit err, output int stalls, output logic [31:0] rdv,
                       output logic [31:0] word_after, output bit chk_word);
    logic [31:0] idx, word, v, sh;
    idx = addr / 4;
    sh  = 32'(addr % 4) * 8;
    err = (rd || wr) && ((rd && wr) || size == 2'd3 || (size == 2'd1 && addr % 2 != 0) ||
                         (size == 2'd2 && addr % 4 != 0) || idx >= 32'(DEPTH));
    chk_word = idx < 32'(DEPTH);
    word = chk_word ? ref_mem[idx[9:0]] : 32'h0;
    stalls = 0;
    if (err) begin
      m_rd = 32'h0;
    end else if (rd) begin
      stalls = 1;
      if (size == 2'd0) begin
        v = (word >> sh) % 256;
        if (!uns && v > 127) v = v + 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
        v = (word >> ((addr % 4 >= 2) ? 16 : 0)) % 65536;
        if (!uns && v > 32767) v = v + 32'hFFFF_0000;
      end else begin
        v = word;
      end
      m_rd = v;
    end else if (wr) begin
      if (size == 2'd2) begin
        word = wdata;
      end else if (size == 2'd0) begin
        stalls = 1;
        word = (word & ~(32'hFF << sh)) | ((wdata % 256) << sh);
      end else begin
        stalls = 1;
        sh = (addr % 4 >= 2) ? 32'd16 : 32'd0;
        word = (word & ~(32'hFFFF << sh)) | ((wdata % 65536) << sh);
      end
      ref_mem[idx[9:0]] = word;
    end
    rdv = m_rd;
    word_after = word;
  endtask

  // Runs one MEM-stage instruction, holding inputs while stalled
  task automatic run_op(input string nm, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit rd, input bit wr, input logic [1:0] size, input bit uns,
                        input bit exp_err, input int exp_stalls, input logic [31:0] exp_rd,
                        input logic [31:0] exp_word, input bit chk_word);
    int n;
    @(negedge Clk);
    drive(addr, wdata, rd, wr, size, uns);
    #1;
    check({nm, " addr_err"}, 32'(bus.Addr_Error_MEM), 32'(exp_err));
    check({nm, " mem_addr"}, bus.Mem_Addr, addr >> 2);
    check({nm, " mem_read"}, 32'(bus.Mem_Read), 32'((rd || (wr && size != 2'd2)) && !exp_err));
    n = 0;
    while (bus.Stall_MEM && n < 4) begin
      @(negedge Clk); #1;
      n++;
    end
    check({nm, " stalls"}, 32'(n), 32'(exp_stalls));
    check({nm, " mem_write"}, 32'(bus.Mem_Write), 32'(wr && !exp_err));
    if (wr && !exp_err) check({nm, " wdata"}, bus.Mem_Write_Data, exp_word);
    if (rd && !exp_err) check({nm, " rdata_hold"}, bus.Read_Data_MEM, exp_rd);
    @(negedge Clk);
    drive(32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    #1;
    check({nm, " rdata"}, bus.Read_Data_MEM, exp_rd);
    check({nm, " idle_en"}, {29'h0, bus.Mem_Read, bus.Mem_Write, bus.Stall_MEM}, 32'h0);
    if (chk_word) check({nm, " word"}, mem[10'(addr >> 2)], exp_word);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          rd;
    bit          wr;
    logic [1:0]  size;
    bit          uns;
    bit          err;
    int          stalls;
    logic [31:0] rd_exp;
    logic [31:0] word_exp;
    bit          chk_word;
  } vec_t;

  function automatic vec_t mk(string nm, logic [31:0] addr, logic [31:0] wdata, bit rd, bit wr,
                              logic [1:0] size, bit uns, bit err, int stalls,
                              logic [31:0] rd_exp, logic [31:0] word_exp, bit chk_word);
    vec_t v;
    v.nm = nm; v.addr = addr; v.wdata = wdata; v.rd = rd; v.wr = wr; v.size = size; v.uns = uns;
    v.err = err; v.stalls = stalls; v.rd_exp = rd_exp; v.word_exp = word_exp; v.chk_word = chk_word;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    bit e, cw;
    int s;
    logic [31:0] rv, wa;

    Reset = 1'b1;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    m_rd = 32'h0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);

    for (int i = 0; i < 32; i++) preload(i, $urandom);
    preload(4, 32'h1122_3344);
    preload(5, 32'h8899_AABB);
    preload(8, 32'h0000_0000);
    preload(1023, 32'h0BAD_F00D);
    @(negedge Clk);
    pre_we = 1'b0;

    // Strobes stay low under reset whatever is requested
    drive(32'h14, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    #1;
    check("rst mem_read", 32'(bus.Mem_Read), 32'h0);
    check("rst stall", 32'(bus.Stall_MEM), 32'h0);
    drive(32'h15, 32'h0, 1'b1, 1'b1, 2'd3, 1'b0);
    #1;
    check("rst addr_err", 32'(bus.Addr_Error_MEM), 32'h0);
    check("rst mem_write", 32'(bus.Mem_Write), 32'h0);
    @(negedge Clk);
    drive(32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    Reset = 1'b0;
    #1;
    check("rst rdata", bus.Read_Data_MEM, 32'h0);
    check("rst idle_en", {29'h0, bus.Mem_Read, bus.Mem_Write, bus.Stall_MEM}, 32'h0);

    tbl.push_back(mk("LB15",   32'h15,  32'h0,        1, 0, 2'd0, 0, 0, 1, 32'hFFFF_FFAA, 32'h8899_AABB, 1));
    tbl.push_back(mk("LHU16",  32'h16,  32'h0,        1, 0, 2'd1, 1, 0, 1, 32'h0000_8899, 32'h8899_AABB, 1));
    tbl.push_back(mk("LH14",   32'h14,  32'h0,        1, 0, 2'd1, 0, 0, 1, 32'hFFFF_AABB, 32'h8899_AABB, 1));
    tbl.push_back(mk("LBU15",  32'h15,  32'h0,        1, 0, 2'd0, 1, 0, 1, 32'h0000_00AA, 32'h8899_AABB, 1));
    tbl.push_back(mk("SB17",   32'h17,  32'h12,       0, 1, 2'd0, 0, 0, 1, 32'h0000_00AA, 32'h1299_AABB, 1));
    tbl.push_back(mk("LW14",   32'h14,  32'h0,        1, 0, 2'd2, 0, 0, 1, 32'h1299_AABB, 32'h1299_AABB, 1));
    tbl.push_back(mk("SW20",   32'h20,  32'hDEAD_BEEF, 0, 1, 2'd2, 0, 0, 0, 32'h1299_AABB, 32'hDEAD_BEEF, 1));
    tbl.push_back(mk("LW20",   32'h20,  32'h0,        1, 0, 2'd2, 0, 0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1));
    tbl.push_back(mk("LW22",   32'h22,  32'h0,        1, 0, 2'd2, 0, 1, 0, 32'h0,         32'hDEAD_BEEF, 1));
    tbl.push_back(mk("SH13",   32'h13,  32'h5555,     0, 1, 2'd1, 0, 1, 0, 32'h0,         32'h1122_3344, 1));
    tbl.push_back(mk("LW1000", 32'h1000, 32'h0,       1, 0, 2'd2, 0, 1, 0, 32'h0,         32'h0,         0));
    tbl.push_back(mk("SH12",   32'h12,  32'hCAFE,     0, 1, 2'd1, 0, 0, 1, 32'h0,         32'hCAFE_3344, 1));
    tbl.push_back(mk("RDWR10", 32'h10,  32'h0,        1, 1, 2'd2, 0, 1, 0, 32'h0,         32'hCAFE_3344, 1));
    tbl.push_back(mk("ILL10",  32'h10,  32'h0,        1, 0, 2'd3, 0, 1, 0, 32'h0,         32'hCAFE_3344, 1));
    tbl.push_back(mk("LB12",   32'h12,  32'h0,        1, 0, 2'd0, 0, 0, 1, 32'hFFFF_FFFE, 32'hCAFE_3344, 1));
    tbl.push_back(mk("LWFFC",  32'hFFC, 32'h0,        1, 0, 2'd2, 0, 0, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1));
    tbl.push_back(mk("SB10",   32'h10,  32'hABCD_EF77, 0, 1, 2'd0, 0, 0, 1, 32'h0BAD_F00D, 32'hCAFE_3377, 1));

    foreach (tbl[i]) begin
      model(tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].wr, tbl[i].size, tbl[i].uns, e, s, rv, wa, cw);
      run_op(tbl[i].nm, tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].wr, tbl[i].size, tbl[i].uns,
             tbl[i].err, tbl[i].stalls, tbl[i].rd_exp, tbl[i].word_exp, tbl[i].chk_word);
    end

    // Reset during RMW_WRITE drops the pending halfword store
    @(negedge Clk);
    drive(32'h10, 32'h0000_BEEF, 1'b0, 1'b1, 2'd1, 1'b0);
    #1;
    check("rmwrst stall", 32'(bus.Stall_MEM), 32'h1);
    check("rmwrst mem_read", 32'(bus.Mem_Read), 32'h1);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("rmwrst mem_write", 32'(bus.Mem_Write), 32'h0);
    check("rmwrst stall2", 32'(bus.Stall_MEM), 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    #1;
    m_rd = 32'h0;
    check("rmwrst word4", mem[4], 32'hCAFE_3377);
    check("rmwrst rdata", bus.Read_Data_MEM, 32'h0);
    run_op("rmwrst LW10", 32'h10, 32'h0, 1, 0, 2'd2, 0, 0, 1, 32'hCAFE_3377, 32'hCAFE_3377, 1);
    m_rd = 32'hCAFE_3377;

    // Reset during LOAD_HOLD clears the load result
    @(negedge Clk);
    drive(32'h14, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    @(negedge Clk);
    #1;
    check("ldrst hold", bus.Read_Data_MEM, 32'h1299_AABB);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    #1;
    check("ldrst rdata", bus.Read_Data_MEM, 32'h0);
    m_rd = 32'h0;

    // Random accesses against the reference model
    for (int k = 0; k < 300; k++) begin
      logic [31:0] addr, wdata;
      logic [1:0]  size;
      bit          rd, wr, uns;
      int          r;
      addr = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(1024, 1030)) * 4 : 32'($urandom_range(0, 15)) * 4;
      addr = addr + 32'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      r = $urandom_range(0, 9);
      rd = (r < 4) || (r == 8);
      wr = (r >= 4 && r < 9);
      uns = 1'($urandom_range(0, 1));
      wdata = $urandom;
      model(addr, wdata, rd, wr, size, uns, e, s, rv, wa, cw);
      run_op("rnd", addr, wdata, rd, wr, size, uns, e, s, rv, wa, cw);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
